// File: rtl/game_pkg.sv
// Shared encodings and playfield geometry for the gravity-run game controller.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GROUND = 2'b01,
    ST_AIR    = 2'b10,
    ST_DEAD   = 2'b11
  } state_t;

  localparam int LINE0_H  = 120;
  localparam int LINE1_H  = 240;
  localparam int LINE2_H  = 360;
  localparam int PLAYER_H = 60;

  // Top-left heights at which a falling player rests on line 1 / line 2.
  localparam int LAND1_H = LINE1_H - PLAYER_H;
  localparam int LAND2_H = LINE2_H - PLAYER_H;

endpackage

// File: rtl/step_tick_gen.sv
// Movement-step divider: counts 0..TICK_DIV-1 while enabled and strobes
// step_en for one cycle after each terminal count.
module step_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic step_en
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_max;

  assign at_max = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt     <= '0;
      step_en <= 1'b0;
    end else if (en) begin
      cnt     <= at_max ? '0 : cnt + 1'b1;
      step_en <= at_max;
    end else begin
      step_en <= 1'b0;
    end
  end

endmodule

// File: rtl/gravity_run_ctrl.sv
// Run sequencer for the player-height datapath: gravity direction, flip
// buffering, grounded/dead detection, step strobe and score.
//
// state  | meaning
// IDLE   | movement block held in reset, waiting for start
// GROUND | standing on a line, flips apply immediately
// AIR    | moving between lines, one flip may be buffered
// DEAD   | height frozen for display, waiting for start
module gravity_run_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int MAX_H    = 420,
  parameter int MIN_H    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flip_btn,
  input  logic [8:0]  height,
  input  logic [2:0]  lines,
  output logic        grav_dir,
  output logic        step_en,
  output logic        player_rst_n,
  output logic [1:0]  state,
  output logic [15:0] score
);

  state_t      st_q, st_d;
  logic        grav_q, grav_d;
  logic        buf_q, buf_d;
  logic        restart_q, restart_d;
  logic        flip_q;
  logic [15:0] score_q;
  logic        grounded, dead_cond, flip_edge;
  logic        run_start, tick_clr, tick_en;

  assign grounded = grav_q
    ? ((height == 9'(LINE0_H) && lines[0]) || (height == 9'(LINE1_H) && lines[1]))
    : ((height == 9'(LAND1_H) && lines[1]) || (height == 9'(LAND2_H) && lines[2]));

  assign dead_cond = (int'(height) >= MAX_H) ||
                     ((int'(height) <= MIN_H) && grav_q && !grounded);

  assign flip_edge = flip_btn && !flip_q;

  always_comb begin
    st_d         = st_q;
    grav_d       = grav_q;
    buf_d        = buf_q;
    restart_d    = 1'b0;
    run_start    = 1'b0;
    player_rst_n = 1'b1;
    case (st_q)
      ST_IDLE: begin
        player_rst_n = 1'b0;
        if (start || restart_q) run_start = 1'b1;
      end
      ST_GROUND, ST_AIR: begin
        if (dead_cond) begin
          st_d = ST_DEAD;
        end else if (start) begin
          run_start = 1'b1;
        end else if (st_q == ST_GROUND && (flip_edge || buf_q)) begin
          grav_d = !grav_q;
          buf_d  = 1'b0;
          st_d   = ST_AIR;
        end else begin
          if (st_q == ST_AIR && flip_edge) buf_d = 1'b1;
          st_d = grounded ? ST_GROUND : ST_AIR;
        end
      end
      ST_DEAD: begin
        // Pass through IDLE for one cycle so the movement block is reset.
        if (start) begin
          st_d      = ST_IDLE;
          restart_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (run_start) begin
      st_d   = ST_GROUND;
      grav_d = 1'b0;
      buf_d  = 1'b0;
    end
  end

  assign tick_en  = (st_q == ST_GROUND) || (st_q == ST_AIR);
  assign tick_clr = run_start || (st_d == ST_IDLE) || (st_d == ST_DEAD);

  step_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clr     (tick_clr),
    .en      (tick_en),
    .step_en (step_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= ST_IDLE;
      grav_q    <= 1'b0;
      buf_q     <= 1'b0;
      restart_q <= 1'b0;
      flip_q    <= 1'b0;
      score_q   <= '0;
    end else begin
      st_q      <= st_d;
      grav_q    <= grav_d;
      buf_q     <= buf_d;
      restart_q <= restart_d;
      flip_q    <= flip_btn;
      if (run_start)                        score_q <= '0;
      else if (step_en && score_q != '1)    score_q <= score_q + 16'd1;
    end
  end

  assign grav_dir = grav_q;
  assign state    = st_q;
  assign score    = score_q;

endmodule

// File: tb/tb_gravity_run_ctrl.sv
// Directed walk through the run sequence followed by random play, every
// cycle compared against a rule-level model of the controller.
module tb_gravity_run_ctrl;

  localparam int TICK = 4;
  localparam int MAXH = 420;
  localparam int MINH = 0;

  logic        clk = 1'b0;
  logic        reset, start, flip_btn;
  logic [8:0]  height;
  logic [2:0]  lines;
  logic        grav_dir, step_en, player_rst_n;
  logic [1:0]  state;
  logic [15:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 idle, 1 ground, 2 air, 3 dead
  int m_st, m_score, m_cnt;
  bit m_grav, m_buf, m_fq, m_restart, m_step;

  gravity_run_ctrl #(.TICK_DIV(TICK), .MAX_H(MAXH), .MIN_H(MINH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flip_btn     (flip_btn),
    .height       (height),
    .lines        (lines),
    .grav_dir     (grav_dir),
    .step_en      (step_en),
    .player_rst_n (player_rst_n),
    .state        (state),
    .score        (score)
  );

  always #5 clk = ~clk;

  function automatic bit on_line(bit up, int h, logic [2:0] l);
    if (up) return (h == 120 && l[0]) || (h == 240 && l[1]);
    return (h == 180 && l[1]) || (h == 300 && l[2]);
  endfunction

  task automatic model_edge();
    bit g, dead, fe, go;
    int nst;
    if (reset) begin
      m_st = 0; m_grav = 0; m_buf = 0; m_fq = 0; m_restart = 0;
      m_step = 0; m_score = 0; m_cnt = 0;
      return;
    end
    g    = on_line(m_grav, int'(height), lines);
    dead = (int'(height) >= MAXH) || (int'(height) <= MINH && m_grav && !g);
    fe   = flip_btn && !m_fq;
    nst  = m_st;
    go   = 0;
    if (m_st == 0) begin
      go = start || m_restart;
      m_restart = 0;
    end else if (m_st == 3) begin
      if (start) begin nst = 0; m_restart = 1; end
    end else begin
      if (dead) nst = 3;
      else if (start) go = 1;
      else if (m_st == 1 && (fe || m_buf)) begin
        m_grav = !m_grav; m_buf = 0; nst = 2;
      end else begin
        if (m_st == 2 && fe) m_buf = 1;
        nst = g ? 1 : 2;
      end
    end
    if (go) begin
      m_score = 0; nst = 1; m_grav = 0; m_buf = 0;
    end else if (m_step && m_score < 16'hFFFF) begin
      m_score++;
    end
    // step strobe follows every TICK-th run cycle since the run (re)started
    if (!go && (m_st == 1 || m_st == 2) && (nst == 1 || nst == 2)) begin
      m_cnt++;
      m_step = (m_cnt % TICK) == 0;
    end else begin
      m_cnt = 0;
      m_step = 0;
    end
    m_st = nst;
    m_fq = flip_btn;
  endtask

  task automatic chk(string tag, string what, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk(tag, "state", 16'(state), 16'(m_st));
    chk(tag, "grav_dir", 16'(grav_dir), 16'(m_grav));
    chk(tag, "step_en", 16'(step_en), 16'(m_step));
    chk(tag, "player_rst_n", 16'(player_rst_n), 16'(m_st != 0));
    chk(tag, "score", score, 16'(m_score));
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  int pulses;
  logic [15:0] held;
  int hset[10] = '{0, 120, 180, 240, 300, 360, 420, 60, 479, 200};

  initial begin
    reset = 1; start = 0; flip_btn = 0; height = 9'd180; lines = 3'b010;
    cyc("reset"); cyc("reset");
    chk("reset", "state_const", 16'(state), 16'h0);
    reset = 0;
    cyc("idle");
    start = 1; cyc("start"); start = 0;
    chk("start", "ground_const", 16'(state), 16'h1);
    chk("start", "prst_const", 16'(player_rst_n), 16'h1);

    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc("run12");
      if (step_en === 1'b1) pulses++;
    end
    chk("run12", "pulse_count", 16'(pulses), 16'd3);

    flip_btn = 1; cyc("flip");
    chk("flip", "grav_const", 16'(grav_dir), 16'h1);
    chk("flip", "air_const", 16'(state), 16'h2);
    for (int i = 0; i < 3; i++) cyc("hold");
    chk("hold", "grav_const", 16'(grav_dir), 16'h1);
    flip_btn = 0; cyc("rel");

    flip_btn = 1; cyc("edge1"); flip_btn = 0; cyc("edge1");
    flip_btn = 1; cyc("edge2"); flip_btn = 0; cyc("edge2");
    height = 9'd120; lines = 3'b001;
    cyc("land");
    cyc("apply");
    chk("apply", "grav_const", 16'(grav_dir), 16'h0);
    chk("apply", "air_const", 16'(state), 16'h2);
    for (int i = 0; i < 4; i++) cyc("dropped");

    height = 9'd420; flip_btn = 1; start = 1;
    cyc("dead");
    chk("dead", "dead_const", 16'(state), 16'h3);
    held = score;
    start = 0; flip_btn = 0;
    for (int i = 0; i < 6; i++) cyc("dead_hold");
    chk("dead_hold", "score_held", score, held);

    start = 1; cyc("restart");
    chk("restart", "prst_low", 16'(player_rst_n), 16'h0);
    start = 0; height = 9'd180; lines = 3'b010;
    cyc("restart2");
    chk("restart2", "ground_const", 16'(state), 16'h1);
    chk("restart2", "score_zero", score, 16'h0);

    cyc("pre_sat");
    force dut.score_q = 16'hFFFE;
    #1 release dut.score_q;
    m_score = 16'hFFFE;
    for (int i = 0; i < 14; i++) cyc("sat");
    chk("sat", "score_const", score, 16'hFFFF);
    flip_btn = 1; cyc("to_air"); flip_btn = 0;
    reset = 1; cyc("mid_reset"); reset = 0;
    chk("mid_reset", "idle_const", 16'(state), 16'h0);
    chk("mid_reset", "grav_const", 16'(grav_dir), 16'h0);

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) flip_btn = ~flip_btn;
      if ($urandom_range(0, 3) == 0) height = 9'(hset[$urandom_range(0, 9)]);
      if ($urandom_range(0, 3) == 0) lines = 3'($urandom_range(0, 7));
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
